// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the two masters and the arbiter.
interface bus_arbiter_if;

    logic m0_req;
    logic m1_req;
    logic m0_grant;
    logic m1_grant;
    logic sel;
    logic busy;

    modport master (
        output m0_req, m1_req,
        input  m0_grant, m1_grant, sel, busy
    );

    modport slave (
        input  m0_req, m1_req,
        output m0_grant, m1_grant, sel, busy
    );

endinterface

// File: rtl/bus_arbiter_tenure_cnt.sv
// Tenure counter: clears on ownership change, counts held cycles, saturates at MAX_TENURE-1.
module arb_tenure_cnt #(
    parameter int unsigned MAX_TENURE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam int unsigned CW = $clog2(MAX_TENURE);
    localparam logic [CW-1:0] TC = CW'(MAX_TENURE - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != TC)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with registered grants and mux select.
// Optional tenure limit under contention: define BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned MAX_TENURE = 8
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);

    state_t r_state;
    state_t w_next;
    logic   r_last_owner;
    logic   w_preempt;

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic w_tc;

    arb_tenure_cnt #(
        .MAX_TENURE (MAX_TENURE)
    ) u_tenure_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_next != r_state),
        .i_inc (r_state != IDLE),
        .o_tc  (w_tc)
    );

    assign w_preempt = w_tc;
`else
    assign w_preempt = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    w_next = (r_last_owner == M0) ? GRANT1 : GRANT0;
                end else if (bus.m0_req) begin
                    w_next = GRANT0;
                end else if (bus.m1_req) begin
                    w_next = GRANT1;
                end
            end
            GRANT0: begin
                if (!bus.m0_req) begin
                    w_next = bus.m1_req ? GRANT1 : IDLE;
                end else if (bus.m1_req && w_preempt) begin
                    w_next = GRANT1;
                end
            end
            GRANT1: begin
                if (!bus.m1_req) begin
                    w_next = bus.m0_req ? GRANT0 : IDLE;
                end else if (bus.m0_req && w_preempt) begin
                    w_next = GRANT0;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_owner <= M1;
        end else begin
            r_state <= w_next;
            if ((w_next == GRANT0) && (r_state != GRANT0)) begin
                r_last_owner <= M0;
            end else if ((w_next == GRANT1) && (r_state != GRANT1)) begin
                r_last_owner <= M1;
            end
        end
    end

    // Outputs depend only on the state register, never on requests.
    assign bus.m0_grant = (r_state == GRANT0);
    assign bus.m1_grant = (r_state == GRANT1);
    assign bus.sel      = (r_state == GRANT1);
    assign bus.busy     = (r_state == GRANT0) || (r_state == GRANT1);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic vs an ownership model.
module tb_bus_arbiter;

    localparam int MAX_T = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    bus_arbiter_if bif ();

    bus_arbiter #(
        .MAX_TENURE (MAX_T)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner is -1 (none), 0 or 1; held counts granted cycles since ownership began.
    int m_owner = -1;
    int m_last  = 1;
    int m_held  = 0;
    bit m_valid = 1'b0;

    initial begin
        bit s_rst;
        bit s_req [2];
        int nxt;
        forever begin
            @(posedge clk);
            s_rst    = rst;
            s_req[0] = bif.m0_req;
            s_req[1] = bif.m1_req;
            if (s_rst) begin
                m_owner = -1;
                m_last  = 1;
                m_held  = 0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                nxt = m_owner;
                if (m_owner < 0) begin
                    if (s_req[0] && s_req[1]) nxt = 1 - m_last;
                    else if (s_req[0])        nxt = 0;
                    else if (s_req[1])        nxt = 1;
                end else if (!s_req[m_owner]) begin
                    nxt = s_req[1 - m_owner] ? 1 - m_owner : -1;
                end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
                    if (s_req[1 - m_owner] && (m_held == MAX_T - 1)) nxt = 1 - m_owner;
`endif
                end
                if (nxt != m_owner) begin
                    m_held = 0;
                    if (nxt >= 0) m_last = nxt;
                end else if (nxt >= 0 && m_held < MAX_T - 1) begin
                    m_held++;
                end
                m_owner = nxt;
            end
            @(negedge clk);
            if (m_valid) begin
                check("m0_grant", 32'(bif.m0_grant), 32'(m_owner == 0));
                check("m1_grant", 32'(bif.m1_grant), 32'(m_owner == 1));
                check("sel",      32'(bif.sel),      32'(m_owner == 1));
                check("busy",     32'(bif.busy),     32'(m_owner >= 0));
                check("exclusive", 32'(bif.m0_grant & bif.m1_grant), 32'd0);
            end
        end
    end

    task automatic cyc(input logic r, input logic a, input logic b);
        @(negedge clk);
        rst        = r;
        bif.m0_req = a;
        bif.m1_req = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   cnt;
        logic g0 [20];
        logic a;
        logic b;

        bif.m0_req = 1'b0;
        bif.m1_req = 1'b0;

        // Reset held with both requests active
        cyc(1, 1, 1);
        check("rst_busy_0", 32'(bif.busy), 32'd0);
        cyc(1, 1, 1);
        check("rst_busy_1", 32'(bif.busy), 32'd0);
        check("rst_sel", 32'(bif.sel), 32'd0);
        cyc(0, 1, 1);
        check("post_rst_m0", 32'(bif.m0_grant), 32'd1);
        check("post_rst_sel", 32'(bif.sel), 32'd0);
        cyc(0, 0, 0);
        check("release_idle", 32'(bif.busy), 32'd0);

        // Single master 1 for five cycles
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1);
            if (bif.m1_grant && bif.sel) cnt++;
        end
        check("single_m1_cycles", 32'(cnt), 32'd5);
        cyc(0, 0, 0);
        check("single_m1_drop", 32'(bif.busy), 32'd0);

        // Round-robin ties after a master-0 tenure
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 1);
        check("tie_to_m1", 32'(bif.m1_grant), 32'd1);
        cyc(0, 0, 0);
        cyc(0, 1, 1);
        check("tie_to_m0", 32'(bif.m0_grant), 32'd1);

        // Direct handover without an idle cycle
        cyc(0, 1, 1);
        check("handover_pre", 32'(bif.m0_grant), 32'd1);
        cyc(0, 0, 1);
        check("handover_m0", 32'(bif.m0_grant), 32'd0);
        check("handover_m1", 32'(bif.m1_grant), 32'd1);
        check("handover_sel", 32'(bif.sel), 32'd1);
        check("handover_busy", 32'(bif.busy), 32'd1);
        cyc(0, 0, 0);

        // Sustained contention starting from a master-0 win (last owner is 1)
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 1);
            g0[i] = bif.m0_grant;
        end
        for (int i = 0; i < 20; i++) begin
`ifdef BUS_ARBITER_TIMEOUT_EN
            check("tenure_alternate", 32'(g0[i]), 32'(((i / MAX_T) % 2) == 0));
`else
            check("tenure_hold", 32'(g0[i]), 32'd1);
`endif
        end
        cyc(0, 0, 0);

        // Reset in the middle of a master-1 tenure
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        check("mid_pre_m1", 32'(bif.m1_grant), 32'd1);
        cyc(1, 0, 1);
        check("mid_rst_busy", 32'(bif.busy), 32'd0);
        cyc(0, 1, 1);
        check("mid_rst_tie_m0", 32'(bif.m0_grant), 32'd1);

        // Randomized traffic; requests tend to persist to form real tenures
        a = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) a = ~a;
            if ($urandom_range(3) == 0) b = ~b;
            cyc(($urandom_range(99) == 0), a, b);
        end

        cyc(0, 0, 0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master bus arbiter for the simple shared bus. It sits directly upstream of the 2-to-1 data mux and produces that mux's select line. It also produces per-master grant strobes for the requesting masters. Grants are registered. Arbitration is round-robin when both masters request, and ownership is held until the owner releases its request or, optionally, until a tenure limit expires.

## Interface
Parameters:
- MAX_TENURE, 8, maximum consecutive grant cycles for one master while the other is requesting. Legal range ≥ 2. Used only when the timeout feature is compiled in.

Ports:
- clk  input  1  bus clock; all state updates on the rising edge.
- rst  input  1  reset: synchronous and active-high.
- m0_req  input  1  master 0 requests or holds the bus.
- m1_req  input  1  master 1 requests or holds the bus.
- m0_grant  output  1  master 0 owns the bus (registered).
- m1_grant  output  1  master 1 owns the bus (registered).
- sel  output  1  mux select: 1 = master 1 data path, 0 = master 0 data path / idle (registered).
- busy  output  1  bus owned: m0_grant | m1_grant.

## Operation
- States: IDLE, GRANT0, GRANT1.
- Outputs decoded from registered state, with no combinational path from req to any output:
  - IDLE gives all outputs 0.
  - GRANT0 gives m0_grant=1 and sel=0.
  - GRANT1 gives m1_grant=1 and sel=1.
- last_owner register: 1 bit, records the most recently granted master. Reset value 1, so master 0 wins the first tie.
- IDLE transitions:
  - Only m0_req → GRANT0.
  - Only m1_req → GRANT1.
  - Both requests → the master ≠ last_owner.
  - Neither → stay in IDLE.
- GRANT0 transitions (GRANT1 is symmetric):
  - m0_req=1 → stay, unless preempted (see Configuration).
  - m0_req=0 and m1_req=1 → GRANT1 directly, with no idle cycle.
  - m0_req=0 and m1_req=0 → IDLE.
- last_owner updates on every entry into GRANT0 or GRANT1.
- Grants are mutually exclusive in every cycle. m0_grant & m1_grant = 1 is illegal.
- rst=1 at any edge, including mid-tenure, forces IDLE, last_owner=1 and tenure count 0, regardless of requests.

## Timing
- Grant latency: a request sampled high at edge N is granted in the cycle after edge N (1 cycle) if the bus is free.
- Release latency: owner req sampled low at edge N drops its grant after edge N.
- Handover: the other master's grant rises at that same edge. sel toggles at that same edge.
- Reset: outputs read 0 in the cycle after the edge where rst is sampled high. The first grant can come one cycle after rst deasserts.

## Configuration
- Macro: BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A tenure counter of width $clog2(MAX_TENURE) holds 0 on the first granted cycle. It increments each cycle the grant is held and saturates at MAX_TENURE-1.
  - The counter clears on every state change.
  - If the count equals MAX_TENURE-1, the owner still requests and the other master requests, the next state is the other grant. The owner therefore holds at most MAX_TENURE cycles under contention.
  - With no competing request, the owner keeps the bus indefinitely and the counter stays saturated.
- Undefined: no counter logic. The owner keeps the bus until it drops its request. MAX_TENURE is ignored.

## Structure
- Shared package bus_pkg holds:
  - the state encoding constants (IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10);
  - the master ID constants M0=1'b0 and M1=1'b1.
- Sub-module arb_tenure_cnt holds the clear/increment/saturate counter. It exposes a terminal-count flag and is instantiated only under BUS_ARBITER_TIMEOUT_EN.
- Everything else (next-state logic, state register, output decode) lives in bus_arbiter.

## Test plan
- Reset: assert rst for 2 cycles with m0_req=m1_req=1 → all outputs 0 during reset. m0_grant=1 and sel=0 one cycle after rst drops.
- Single master: m1_req high for 5 cycles then low → m1_grant and sel high for exactly 5 cycles, one cycle delayed. Then all outputs 0.
- Tie round-robin: from IDLE after a master-0 tenure, both requests rise together → GRANT1. Repeat after release → GRANT0.
- Direct handover: m0 owns the bus. m1_req=1, then m0_req drops at edge N → m0_grant falls and m1_grant and sel rise at edge N. busy stays 1 throughout.
- Timeout (macro on, MAX_TENURE=8): both requests held constantly → grants alternate every 8 cycles. Macro off → m0 holds forever.
- Mid-tenure reset: rst pulsed during GRANT1 at count 3 → IDLE next cycle. The following tie goes to master 0.
